xge_tx_pkt_buffer: RTL and testbench
====================================

// Module: xge_tx_pkt_buffer
// PURPOSE
//  Store-and-forward packet buffer sitting directly upstream of xge_mac TX packet interface.
//  Accepts 64-bit packet words from the switch/host side, holds each packet until its EOP word
//  is written, then streams the whole packet into pkt_tx_* honouring pkt_tx_full back-pressure.
//  Guarantees the MAC never sees a partial or underrun packet; aborted/overflowing packets are dropped.
// PARAMETERS
//  DEPTH    512  buffer depth in 64-bit words; power of two, >= 16
//  ADDR_W   9    log2(DEPTH)
//  CNT_W    16   width of drop/packet statistics counters
// PORTS
//  clk_156m25      in   1   core clock, all logic rising-edge
//  reset_156m25_n  in   1   asynchronous active-low reset
//  in_data         in   64  packet word, byte 0 in [7:0]
//  in_val          in   1   word valid
//  in_sop          in   1   first word of packet
//  in_eop          in   1   last word of packet
//  in_mod          in   3   valid bytes in EOP word; 0 = all 8
//  in_ready        out  1   buffer not full; words offered while low are overflow
//  pkt_tx_data     out  64  to xge_mac
//  pkt_tx_val      out  1   to xge_mac
//  pkt_tx_sop      out  1   to xge_mac
//  pkt_tx_eop      out  1   to xge_mac
//  pkt_tx_mod      out  3   to xge_mac, valid only with pkt_tx_eop
//  pkt_tx_full     in   1   xge_mac TX FIFO full
//  pkts_queued     out  ADDR_W+1  complete packets waiting in buffer
//  drop_count      out  CNT_W  packets dropped since reset, saturating
// BEHAVIOUR
//  Reset: all pointers, counters, FSMs cleared; in_ready=1, pkt_tx_*=0, pkts_queued=0, drop_count=0.
//   Buffer contents discarded; packet in flight to MAC is truncated (MAC sees val drop, no EOP).
//  Storage: DEPTH x 69b entries {sop,eop,mod,data}; wr_ptr/rd_ptr/commit_ptr ADDR_W+1 bits, wrap naturally.
//   full = (wr_ptr - rd_ptr) == DEPTH; in_ready = !full (combinational from registered pointers).
//  Write FSM WR_IDLE / WR_PKT:
//   WR_IDLE: in_val&in_sop -> store word; in_eop too -> commit (1-word pkt), stay; else -> WR_PKT.
//            in_val&!in_sop -> word discarded, drop_count+1 once per stray run, stay.
//   WR_PKT:  in_val&!in_sop -> store; on in_eop -> commit_ptr=wr_ptr+1, pkts_queued+1, -> WR_IDLE.
//            in_val&in_sop (missing EOP) -> wr_ptr rewinds to commit_ptr, drop+1, new pkt starts same cycle.
//   WR_DISC: any in_val while full -> wr_ptr rewinds to commit_ptr, drop+1, discard until in_eop,
//            then WR_IDLE. in_sop&in_eop overflow word in WR_IDLE: drop+1, stay WR_IDLE.
//  Read FSM RD_IDLE / RD_SEND / RD_GAP:
//   RD_IDLE: pkts_queued>0 & !pkt_tx_full -> pop SOP word -> RD_SEND (or RD_GAP if 1-word pkt).
//   RD_SEND: each cycle with !pkt_tx_full pop next word; pkt_tx_full=1 -> pkt_tx_val=0 that cycle.
//            pop of EOP word -> pkts_queued-1, -> RD_GAP.
//   RD_GAP:  one forced idle cycle (pkt_tx_val=0) -> RD_IDLE.
//  pkt_tx_* registered: word popped at edge N is on pkt_tx_* after edge N, for exactly one cycle.
//   pkt_tx_full is sampled combinationally when deciding pop; at most one word issued after full rises.
//  Latency: EOP accepted at edge N -> pkt_tx_sop earliest after edge N+2 (buffer empty, full=0).
//  Simultaneous commit & EOP pop same cycle: pkts_queued unchanged.
//  Reader never passes commit_ptr; uncommitted words are never sent.
//  pkt_tx_mod driven from stored mod on EOP word, 0 otherwise; pkt_tx_sop/eop only with pkt_tx_val.
//  drop_count saturates at all-ones.
// TESTING
//  1. Single 8-word pkt, mod=5, full=0 -> 8 consecutive pkt_tx_val, sop word1, eop word8 mod=5, sop 2 cyc after eop in.
//  2. Two back-to-back 1-word pkts (sop&eop) -> two outputs separated by exactly one idle cycle, pkts_queued 2->0.
//  3. 20-word pkt, pkt_tx_full high 5 cycles mid-packet -> val low those cycles, <=1 word after rise, data order intact.
//  4. DEPTH=16, write 20-word pkt without draining -> in_ready drops after 16 words, pkt dropped, drop_count=1, no output.
//  5. SOP, 3 words, new SOP (no EOP), 2-word pkt -> only 2-word pkt sent, drop_count=1.
//  6. Assert reset mid-send of 10-word pkt -> all outputs 0 immediately, pkts_queued=0, next pkt sent cleanly.

Source files
------------

// File: rtl/xge_tx_pkt_buffer.sv
// Store-and-forward TX packet buffer in front of xge_mac: a packet becomes visible
// to the read side only after its EOP word is committed, so the MAC never underruns.
module xge_tx_pkt_buffer #(
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 16
) (
   input  logic              clk_156m25,
   input  logic              reset_156m25_n,
   input  logic [63:0]       in_data,
   input  logic              in_val,
   input  logic              in_sop,
   input  logic              in_eop,
   input  logic [2:0]        in_mod,
   output logic              in_ready,
   output logic [63:0]       pkt_tx_data,
   output logic              pkt_tx_val,
   output logic              pkt_tx_sop,
   output logic              pkt_tx_eop,
   output logic [2:0]        pkt_tx_mod,
   input  logic              pkt_tx_full,
   output logic [ADDR_W:0]   pkts_queued,
   output logic [CNT_W-1:0]  drop_count
);

   typedef enum logic [1:0] {WR_IDLE, WR_PKT, WR_DISC} wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_SEND, RD_GAP} rd_state_t;

   localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]  PTR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   // entry layout: {sop, eop, mod[2:0], data[63:0]}
   logic [68:0]      mem [DEPTH];
   // eop flags mirrored in a small array so the reader knows at pop time that a packet ends
   logic             eop_mem [DEPTH];
   logic [68:0]      rd_word_q;

   wr_state_t        wr_state_q, wr_state_d;
   rd_state_t        rd_state_q, rd_state_d;
   logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]  commit_ptr_q, commit_ptr_d;
   logic [ADDR_W:0]  pkts_queued_q, pkts_queued_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;
   logic             stray_q, stray_d;
   logic             queued_nz_q, queued_nz_d;
   logic             pkt_tx_val_q, pkt_tx_val_d;

   logic             buf_full;
   logic             mem_we;
   logic [ADDR_W:0]  wr_addr;
   logic             commit_inc;
   logic             drop_inc;
   logic             pop;
   logic             pop_eop;

   assign buf_full = (wr_ptr_q - rd_ptr_q) == DEPTH_W;
   assign in_ready = !buf_full;

   always_comb begin
      wr_state_d   = wr_state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      stray_d      = stray_q;
      wr_addr      = wr_ptr_q;
      mem_we       = 1'b0;
      commit_inc   = 1'b0;
      drop_inc     = 1'b0;
      if (in_val && in_sop) stray_d = 1'b0;
      if (in_val) begin
         case (wr_state_q)
            WR_IDLE: begin
               if (!in_sop) begin
                  // a run of words with no SOP counts as one dropped packet
                  drop_inc = !stray_q;
                  stray_d  = 1'b1;
               end else if (buf_full) begin
                  drop_inc = 1'b1;
                  if (!in_eop) wr_state_d = WR_DISC;
               end else begin
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + PTR_ONE;
                  if (in_eop) begin
                     commit_ptr_d = wr_ptr_q + PTR_ONE;
                     commit_inc   = 1'b1;
                  end else begin
                     wr_state_d = WR_PKT;
                  end
               end
            end
            WR_PKT: begin
               if (buf_full) begin
                  wr_ptr_d   = commit_ptr_q;
                  drop_inc   = 1'b1;
                  wr_state_d = in_eop ? WR_IDLE : WR_DISC;
               end else begin
                  mem_we = 1'b1;
                  if (in_sop) begin
                     // missing EOP: abandon the partial packet, restart at the commit point
                     drop_inc = 1'b1;
                     wr_addr  = commit_ptr_q;
                  end
                  wr_ptr_d = wr_addr + PTR_ONE;
                  if (in_eop) begin
                     commit_ptr_d = wr_addr + PTR_ONE;
                     commit_inc   = 1'b1;
                     wr_state_d   = WR_IDLE;
                  end
               end
            end
            WR_DISC: begin
               if (in_eop) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_ptr_d   = rd_ptr_q;
      pop        = 1'b0;
      pop_eop    = 1'b0;
      case (rd_state_q)
         RD_IDLE: pop = queued_nz_q && !pkt_tx_full;
         RD_SEND: pop = !pkt_tx_full;
         RD_GAP:  rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (eop_mem[rd_ptr_q[ADDR_W-1:0]]) begin
            pop_eop    = 1'b1;
            rd_state_d = RD_GAP;
         end else begin
            rd_state_d = RD_SEND;
         end
      end
      pkt_tx_val_d = pop;
      // registered availability adds the cycle that sets commit-to-SOP latency at two edges
      queued_nz_d  = pkts_queued_q != '0;
   end

   always_comb begin
      pkts_queued_d = pkts_queued_q;
      case ({commit_inc, pop_eop})
         2'b10:   pkts_queued_d = pkts_queued_q + PTR_ONE;
         2'b01:   pkts_queued_d = pkts_queued_q - PTR_ONE;
         default: pkts_queued_d = pkts_queued_q;
      endcase
      drop_count_d = drop_count_q;
      if (drop_inc && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_ONE;
   end

   always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
      if (!reset_156m25_n) begin
         wr_state_q    <= WR_IDLE;
         rd_state_q    <= RD_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         pkts_queued_q <= '0;
         drop_count_q  <= '0;
         stray_q       <= 1'b0;
         queued_nz_q   <= 1'b0;
         pkt_tx_val_q  <= 1'b0;
      end else begin
         wr_state_q    <= wr_state_d;
         rd_state_q    <= rd_state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         commit_ptr_q  <= commit_ptr_d;
         pkts_queued_q <= pkts_queued_d;
         drop_count_q  <= drop_count_d;
         stray_q       <= stray_d;
         queued_nz_q   <= queued_nz_d;
         pkt_tx_val_q  <= pkt_tx_val_d;
      end
   end

   always_ff @(posedge clk_156m25) begin
      if (mem_we) begin
         mem[wr_addr[ADDR_W-1:0]]     <= {in_sop, in_eop, in_mod, in_data};
         eop_mem[wr_addr[ADDR_W-1:0]] <= in_eop;
      end
      rd_word_q <= mem[rd_ptr_q[ADDR_W-1:0]];
   end

   assign pkt_tx_val  = pkt_tx_val_q;
   assign pkt_tx_sop  = pkt_tx_val_q & rd_word_q[68];
   assign pkt_tx_eop  = pkt_tx_val_q & rd_word_q[67];
   assign pkt_tx_mod  = (pkt_tx_val_q & rd_word_q[67]) ? rd_word_q[66:64] : 3'd0;
   assign pkt_tx_data = pkt_tx_val_q ? rd_word_q[63:0] : 64'd0;
   assign pkts_queued = pkts_queued_q;
   assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_xge_tx_pkt_buffer.sv
// Scoreboard bench for xge_tx_pkt_buffer: packets are modelled as whole units that are
// either delivered intact and in order or dropped and counted.
`timescale 1ns/1ps
module tb_xge_tx_pkt_buffer;
   localparam int DEPTH = 32, ADDR_W = 5, CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [63:0]       in_data = '0;
   logic              in_val = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic [2:0]        in_mod = '0;
   logic              in_ready;
   logic [63:0]       pkt_tx_data;
   logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
   logic [2:0]        pkt_tx_mod;
   logic              pkt_tx_full = 1'b0;
   logic [ADDR_W:0]   pkts_queued;
   logic [CNT_W-1:0]  drop_count;

   xge_tx_pkt_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk_156m25(clk), .reset_156m25_n(rst_n),
      .in_data(in_data), .in_val(in_val), .in_sop(in_sop), .in_eop(in_eop), .in_mod(in_mod),
      .in_ready(in_ready),
      .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
      .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .pkt_tx_full(pkt_tx_full),
      .pkts_queued(pkts_queued), .drop_count(drop_count));

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
   } word_t;

   word_t exp_q[$];
   int    sop_cyc_q[$];
   int    eop_cyc_q[$];
   int    total = 0, bad = 0;
   int    cyc = 0;
   int    drop_exp = 0;
   bit    stray_open = 1'b0;
   int    full_pct = 0;
   bit    mon_en = 1'b0;
   bit    burst_arm = 1'b0;
   int    burst_left = 0, burst_cycles = 0;
   bit    in_pkt = 1'b0, prev_eop = 1'b0, full_at_edge = 1'b0;
   int    words_in_pkt = 0, words_in_full = 0, max_words_in_full = 0;
   int    pkt_seen = 0;
   int    last_eop_edge = 0;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // monitor: compares every presented word against the scoreboard and owns pkt_tx_full
   initial begin
      word_t e;
      forever begin
         @(negedge clk);
         full_at_edge = pkt_tx_full;
         if (mon_en) begin
            if (pkt_tx_val) begin
               if (full_at_edge) begin
                  words_in_full++;
                  if (words_in_full > max_words_in_full) max_words_in_full = words_in_full;
               end
               check("gap_after_eop", prev_eop, 0);
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_word actual data=%h sop=%b eop=%b required no output",
                           pkt_tx_data, pkt_tx_sop, pkt_tx_eop);
               end else begin
                  e = exp_q.pop_front();
                  if (pkt_tx_data !== e.data || pkt_tx_sop !== e.sop ||
                      pkt_tx_eop !== e.eop || pkt_tx_mod !== e.mod) begin
                     bad++;
                     $display("FAIL word actual data=%h sop=%b eop=%b mod=%0d required data=%h sop=%b eop=%b mod=%0d",
                              pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, e.data, e.sop, e.eop, e.mod);
                  end
               end
               if (pkt_tx_sop) begin
                  in_pkt = 1'b1;
                  words_in_pkt = 1;
                  sop_cyc_q.push_back(cyc);
               end else begin
                  words_in_pkt++;
               end
               if (pkt_tx_eop) begin
                  in_pkt = 1'b0;
                  pkt_seen++;
                  eop_cyc_q.push_back(cyc);
                  $display("rx pkt %0d words=%0d cyc=%0d", pkt_seen, words_in_pkt, cyc);
               end
            end else begin
               check("idle_ctrl", (pkt_tx_sop | pkt_tx_eop | (pkt_tx_mod != 0) | (pkt_tx_data != 0)), 0);
               check("underrun", in_pkt && !full_at_edge, 0);
            end
            prev_eop = pkt_tx_val & pkt_tx_eop;
            if (!full_at_edge) words_in_full = 0;
         end
         if (burst_left > 0) begin
            pkt_tx_full = 1'b1; burst_left--; burst_cycles++;
         end else if (burst_arm && in_pkt && words_in_pkt == 10) begin
            pkt_tx_full = 1'b1; burst_left = 4; burst_arm = 1'b0; burst_cycles++;
         end else begin
            pkt_tx_full = ($urandom_range(99) < full_pct);
         end
      end
   end

   task automatic drive_word(input logic [63:0] d, input logic s, input logic e,
                             input logic [2:0] m, input bit wait_rdy);
      int guard = 0;
      @(negedge clk);
      while (wait_rdy && !in_ready) begin
         in_val = 1'b0;
         guard++;
         if (guard > 2000) begin
            total++; bad++;
            $display("FAIL ready_timeout actual in_ready=0 required 1 within 2000 cycles");
            break;
         end
         @(negedge clk);
      end
      in_data = d; in_sop = s; in_eop = e; in_mod = m; in_val = 1'b1;
      if (e) last_eop_edge = cyc + 1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_val = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      end
   endtask

   task automatic send_pkt(input int len, input bit abort, input logic [2:0] mod);
      word_t pk[$];
      word_t w;
      for (int i = 0; i < len; i++) begin
         w.data = {$urandom, $urandom};
         w.sop  = (i == 0);
         w.eop  = (i == len - 1) && !abort;
         w.mod  = w.eop ? mod : 3'($urandom);
         drive_word(w.data, w.sop, w.eop, w.mod, 1'b1);
         if (!w.eop) w.mod = 3'd0;
         pk.push_back(w);
      end
      stray_open = 1'b0;
      if (abort) drop_exp++;
      else foreach (pk[k]) exp_q.push_back(pk[k]);
   endtask

   task automatic send_stray(input int n);
      for (int i = 0; i < n; i++)
         drive_word({$urandom, $urandom}, 1'b0, 1'($urandom), 3'($urandom), 1'b1);
      if (!stray_open) drop_exp++;
      stray_open = 1'b1;
   endtask

   task automatic wait_drain();
      int g = 0;
      idle(1);
      while ((exp_q.size() != 0 || pkts_queued != 0) && g < 3000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 3000) begin
         total++; bad++;
         $display("FAIL drain_timeout actual pending=%0d required 0", exp_q.size());
      end
      idle(3);
   endtask

   initial begin
      int seen0;
      int g;
      // reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_val", pkt_tx_val, 0);
      check("rst_queued", pkts_queued, 0);
      check("rst_drop", drop_count, 0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // single 8-word packet, mod 5: latency and back-to-back words
      sop_cyc_q.delete(); eop_cyc_q.delete();
      send_pkt(8, 1'b0, 3'd5);
      wait_drain();
      check("t1_pkts", sop_cyc_q.size(), 1);
      if (sop_cyc_q.size() == 1 && eop_cyc_q.size() == 1) begin
         check("t1_sop_latency", sop_cyc_q[0] - last_eop_edge, 2);
         check("t1_span", eop_cyc_q[0] - sop_cyc_q[0], 7);
      end

      // two back-to-back single-word packets
      sop_cyc_q.delete(); eop_cyc_q.delete();
      send_pkt(1, 1'b0, 3'd2);
      send_pkt(1, 1'b0, 3'd0);
      idle(1);
      check("t2_queued_two", pkts_queued, 2);
      wait_drain();
      check("t2_queued_zero", pkts_queued, 0);
      check("t2_pkts", sop_cyc_q.size(), 2);
      if (sop_cyc_q.size() == 2) check("t2_spacing", sop_cyc_q[1] - sop_cyc_q[0], 2);

      // back-pressure burst of 5 cycles in the middle of a 20-word packet
      burst_cycles = 0; max_words_in_full = 0; burst_arm = 1'b1;
      send_pkt(20, 1'b0, 3'd3);
      wait_drain();
      check("t3_burst_cycles", burst_cycles, 5);
      check("t3_words_after_full", max_words_in_full > 1, 0);

      // overflow: 36-word packet into a 32-entry buffer that cannot drain
      for (int i = 0; i < 36; i++) begin
         @(negedge clk);
         if (i == 31) check("t4_ready_before_full", in_ready, 1);
         if (i == 32) check("t4_ready_low_full", in_ready, 0);
         in_data = {$urandom, $urandom}; in_sop = (i == 0); in_eop = (i == 35);
         in_mod = 3'd1; in_val = 1'b1;
      end
      drop_exp++; stray_open = 1'b0;
      idle(2);
      check("t4_drop", drop_count, drop_exp);
      check("t4_ready_back", in_ready, 1);
      check("t4_queued", pkts_queued, 0);
      idle(10);

      // missing EOP followed by a good 2-word packet
      seen0 = pkt_seen;
      send_pkt(4, 1'b1, 3'd0);
      send_pkt(2, 1'b0, 3'd6);
      wait_drain();
      check("t5_drop", drop_count, drop_exp);
      check("t5_pkts", pkt_seen - seen0, 1);

      // randomized traffic with back-pressure, strays and aborts
      full_pct = 25;
      for (int p = 0; p < 40; p++) begin
         int r;
         r = $urandom_range(9);
         if (r == 0) send_stray($urandom_range(3, 1));
         if (r == 1) send_pkt($urandom_range(6, 1), 1'b1, 3'd0);
         send_pkt($urandom_range(12, 1), 1'b0, 3'($urandom));
         if ($urandom_range(1) == 1) idle($urandom_range(2, 1));
      end
      full_pct = 0;
      wait_drain();
      check("rand_drop", drop_count, drop_exp);
      check("rand_queued", pkts_queued, 0);

      // reset while a 10-word packet is being sent
      send_pkt(10, 1'b0, 3'd1);
      idle(1);
      g = 0;
      while (words_in_pkt < 3 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("t6_started", g < 200, 1);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("t6_val", pkt_tx_val, 0);
      check("t6_ctrl", {pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 0);
      check("t6_data_zero", pkt_tx_data != 0, 0);
      check("t6_queued", pkts_queued, 0);
      check("t6_drop", drop_count, 0);
      exp_q.delete(); drop_exp = 0; stray_open = 1'b0;
      in_pkt = 1'b0; prev_eop = 1'b0; words_in_pkt = 0; words_in_full = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      seen0 = pkt_seen;
      send_pkt(5, 1'b0, 3'd7);
      wait_drain();
      check("t6_after_pkts", pkt_seen - seen0, 1);
      check("t6_after_drop", drop_count, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
